// File: rtl/pwm_sched_pkg.sv
// Shared widths, period length, scheduler state and per-channel config payload
// for the pwm phase scheduler.
package pwm_sched_pkg;

  // 11 bits so the counter, compare and phase fields can all hold 1250.
  localparam int unsigned CTR_W      = 11;
  localparam int unsigned PERIOD_MAX = 1250;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [CTR_W-1:0] compare;
    logic [CTR_W-1:0] phase;
  } ch_cfg_t;

  function automatic logic in_range(input logic [CTR_W-1:0] v);
    return (32'(v) <= PERIOD_MAX);
  endfunction

endpackage

// File: rtl/pwm_period_ctr.sv
// Period counter: counts 0..PERIOD_MAX while run is high, held at 0 otherwise.
// Provides a combinational wrap flag and a registered period_sync pulse.
module pwm_period_ctr
  import pwm_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  output logic [CTR_W-1:0] ctr_o,
  output logic             wrap_c_o,
  output logic             period_sync_o
);

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(PERIOD_MAX);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             sync_q;

  always_comb begin
    ctr_d = '0;
    if (run_i && (ctr_q != CTR_LAST)) ctr_d = ctr_q + CTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      sync_q <= run_i && (ctr_q == '0);
    end
  end

  assign ctr_o         = ctr_q;
  assign wrap_c_o      = run_i && (ctr_q == CTR_LAST);
  assign period_sync_o = sync_q;

endmodule

// File: rtl/pwm_phase_scheduler.sv
// Per-channel phase/duty scheduler: shadow bank written by the host, swapped into
// the active bank only at a period wrap (or immediately while stopped).
module pwm_phase_scheduler
  import pwm_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH = 8,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [CTR_W-1:0]        wr_compare,
  input  logic [CTR_W-1:0]        wr_phase,
  output logic                    wr_err,
  input  logic                    commit_req,
  output logic                    commit_done,
  output logic [CTR_W-1:0]        ctr,
  output logic                    period_sync,
  output logic [NUM_CH-1:0]       ch_fire,
  output logic [NUM_CH*CTR_W-1:0] ch_compare
);

  sched_state_t      state_q, state_d;
  logic              wr_ready_q, wr_err_q, commit_done_q;
  logic              wr_acc_c, wr_bad_c, xfer_c, wrap_c;
  logic [CTR_W-1:0]  ctr_w;
  logic [NUM_CH-1:0] hit_c, fire_q;
  ch_cfg_t           shadow_q [NUM_CH];
  ch_cfg_t           active_q [NUM_CH];

  pwm_period_ctr u_ctr (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run),
    .ctr_o         (ctr_w),
    .wrap_c_o      (wrap_c),
    .period_sync_o (period_sync)
  );

  assign wr_acc_c = wr_valid && wr_ready_q;
  assign wr_bad_c = (32'(wr_ch) >= NUM_CH) || !in_range(wr_compare) || !in_range(wr_phase);

  // Commit waits for the last count of a period so every channel switches together.
  always_comb begin
    state_d = state_q;
    xfer_c  = 1'b0;
    unique case (state_q)
      IDLE:    if (commit_req) state_d = PENDING;
      PENDING: if (!run || wrap_c) begin
        xfer_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ready_q    <= 1'b1;
      wr_err_q      <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ready_q    <= (state_d == IDLE);
      wr_err_q      <= wr_acc_c && wr_bad_c;
      commit_done_q <= xfer_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_acc_c && !wr_bad_c) shadow_q[wr_ch] <= '{compare: wr_compare, phase: wr_phase};
      if (xfer_c) active_q <= shadow_q;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit_c[g] = run && (ctr_w == active_q[g].phase);
    assign ch_compare[g*CTR_W +: CTR_W] = active_q[g].compare;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fire_q <= '0;
    else     fire_q <= hit_c;
  end

  assign wr_ready    = wr_ready_q;
  assign wr_err      = wr_err_q;
  assign commit_done = commit_done_q;
  assign ctr         = ctr_w;
  assign ch_fire     = fire_q;

endmodule

// File: tb/tb_pwm_phase_scheduler.sv
// Scoreboard bench for pwm_phase_scheduler: expected pulses are queued with the
// clock-edge number they should appear on and matched as the DUT produces them.
module tb_pwm_phase_scheduler;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CTR_W  = 11;
  localparam int unsigned PMAX   = 1250;

  logic                    clk = 1'b0;
  logic                    rst, run, wr_valid, wr_ready, wr_err;
  logic                    commit_req, commit_done, period_sync;
  logic [2:0]              wr_ch;
  logic [CTR_W-1:0]        wr_compare, wr_phase, ctr;
  logic [NUM_CH-1:0]       ch_fire;
  logic [NUM_CH*CTR_W-1:0] ch_compare;

  always #10 clk = ~clk;

  pwm_phase_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_compare  (wr_compare),
    .wr_phase    (wr_phase),
    .wr_err      (wr_err),
    .commit_req  (commit_req),
    .commit_done (commit_done),
    .ctr         (ctr),
    .period_sync (period_sync),
    .ch_fire     (ch_fire),
    .ch_compare  (ch_compare)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
  } ev_t;

  ev_t               q_sync[$], q_fire[$], q_done[$], q_err[$];
  int unsigned       cyc = 0, commit_edge = 0, exp_ctr = 0;
  int unsigned       n_chk = 0, n_pass = 0;
  logic [CTR_W-1:0]  exp_phase [NUM_CH];
  logic [CTR_W-1:0]  sh_phase  [NUM_CH];
  logic [NUM_CH-1:0] gen_mask;
  logic [31:0]       m_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
  endtask

  // Expected-pulse generator: numbers each edge and queues what that edge must produce.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ctr     = 0;
      commit_edge = 0;
      q_sync.delete();
      q_fire.delete();
      q_done.delete();
      q_err.delete();
      for (int i = 0; i < NUM_CH; i++) begin
        exp_phase[i] = '0;
        sh_phase[i]  = '0;
      end
    end else begin
      cyc++;
      gen_mask = '0;
      for (int i = 0; i < NUM_CH; i++)
        if (run && (32'(exp_phase[i]) == exp_ctr)) gen_mask[i] = 1'b1;
      if (run && exp_ctr == 0) q_sync.push_back('{cyc, 32'd1});
      if (gen_mask != '0) q_fire.push_back('{cyc, 32'(gen_mask)});
      if (cyc == commit_edge)
        for (int i = 0; i < NUM_CH; i++) exp_phase[i] = sh_phase[i];
      exp_ctr = !run ? 0 : ((exp_ctr == PMAX) ? 0 : exp_ctr + 1);
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      m_e = (q_sync.size() != 0 && q_sync[0].cyc == cyc) ? q_sync[0].val : 32'd0;
      if (m_e != 0 || period_sync) check_eq("period_sync", 32'(period_sync), m_e);
      if (q_sync.size() != 0 && q_sync[0].cyc == cyc) q_sync.delete(0);

      m_e = (q_fire.size() != 0 && q_fire[0].cyc == cyc) ? q_fire[0].val : 32'd0;
      if (m_e != 0 || ch_fire != '0) check_eq("ch_fire", 32'(ch_fire), m_e);
      if (q_fire.size() != 0 && q_fire[0].cyc == cyc) q_fire.delete(0);

      m_e = (q_done.size() != 0 && q_done[0].cyc == cyc) ? q_done[0].val : 32'd0;
      if (m_e != 0 || commit_done) check_eq("commit_done", 32'(commit_done), m_e);
      if (q_done.size() != 0 && q_done[0].cyc == cyc) q_done.delete(0);

      m_e = (q_err.size() != 0 && q_err[0].cyc == cyc) ? q_err[0].val : 32'd0;
      if (m_e != 0 || wr_err) check_eq("wr_err", 32'(wr_err), m_e);
      if (q_err.size() != 0 && q_err[0].cyc == cyc) q_err.delete(0);

      if (exp_ctr == PMAX || exp_ctr % 250 == 0) check_eq("ctr", 32'(ctr), exp_ctr);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ctr(input int unsigned v);
    int unsigned n = 0;
    do begin
      tick(1);
      n++;
    end while (exp_ctr != v && n < 3000);
    if (exp_ctr != v) check_eq("wait_ctr_timeout", exp_ctr, v);
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (q_done.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    if (q_done.size() != 0) check_eq("commit_timeout", 32'(q_done.size()), 32'd0);
  endtask

  task automatic wr(input logic [2:0] ch, input logic [CTR_W-1:0] cmp, input logic [CTR_W-1:0] ph);
    check_eq("wr_ready_idle", 32'(wr_ready), 32'd1);
    wr_valid   = 1'b1;
    wr_ch      = ch;
    wr_compare = cmp;
    wr_phase   = ph;
    if (32'(cmp) > PMAX || 32'(ph) > PMAX) q_err.push_back('{cyc + 1, 32'd1});
    else sh_phase[ch] = ph;
    tick(1);
    wr_valid = 1'b0;
  endtask

  // Request issued now lands on the next edge; transfer on the first later edge seeing ctr==PMAX.
  task automatic commit();
    int unsigned k;
    k = (exp_ctr == PMAX) ? PMAX + 1 : PMAX - exp_ctr;
    commit_edge = cyc + 1 + k;
    q_done.push_back('{commit_edge, 32'd1});
    commit_req = 1'b1;
    tick(1);
    commit_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; wr_valid = 1'b0; commit_req = 1'b0;
    wr_ch = '0; wr_compare = '0; wr_phase = '0;
    tick(3);
    check_eq("rst_ctr", 32'(ctr), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_fire", 32'(ch_fire), 32'd0);
    check_eq("rst_compare", 32'(|ch_compare), 32'd0);
    check_eq("rst_done", 32'(commit_done), 32'd0);
    rst = 1'b0;
    run = 1'b1;

    // free-running period
    wait_ctr(PMAX);
    check_eq("ctr_max", 32'(ctr), PMAX);
    tick(1);
    check_eq("ctr_wrap", 32'(ctr), 32'd0);
    wait_ctr(PMAX);
    tick(1);
    check_eq("wr_ready_run", 32'(wr_ready), 32'd1);

    // ch3 phase 100 / compare 625, commit at ctr 10
    wait_ctr(5);
    wr(3'd3, 11'd625, 11'd100);
    wait_ctr(10);
    commit();
    check_eq("pend_wr_ready", 32'(wr_ready), 32'd0);
    wait_done();
    check_eq("cmp_ch3", 32'(ch_compare[3*CTR_W +: CTR_W]), 32'd625);
    wait_ctr(200);

    // out-of-range writes dropped, boundary 1250 accepted
    wait_ctr(300);
    wr(3'd0, 11'd625, 11'd1251);
    wr(3'd1, 11'd1251, 11'd5);
    wr(3'd1, 11'd2047, 11'd2047);
    wr(3'd2, 11'd1250, 11'd1250);
    commit();
    wait_done();
    check_eq("cmp_ch0_kept", 32'(ch_compare[0 +: CTR_W]), 32'd0);
    check_eq("cmp_ch1_kept", 32'(ch_compare[1*CTR_W +: CTR_W]), 32'd0);
    check_eq("cmp_ch2_max", 32'(ch_compare[2*CTR_W +: CTR_W]), 32'd1250);
    wait_ctr(PMAX);
    tick(2);

    // commit exactly on the last count waits a full period; repeat request ignored
    wait_ctr(40);
    wr(3'd4, 11'd10, 11'd20);
    wait_ctr(PMAX);
    commit();
    check_eq("late_wr_ready0", 32'(wr_ready), 32'd0);
    wait_ctr(600);
    commit_req = 1'b1;
    tick(1);
    commit_req = 1'b0;
    check_eq("late_wr_ready1", 32'(wr_ready), 32'd0);
    wait_ctr(1249);
    check_eq("late_wr_ready2", 32'(wr_ready), 32'd0);
    check_eq("late_cmp_ch4", 32'(ch_compare[4*CTR_W +: CTR_W]), 32'd0);
    wait_done();
    check_eq("late_wr_ready3", 32'(wr_ready), 32'd1);
    check_eq("late_cmp_ch4b", 32'(ch_compare[4*CTR_W +: CTR_W]), 32'd10);
    wait_ctr(PMAX);
    tick(3);

    // stopping while pending commits on the next edge
    wr(3'd5, 11'd100, 11'd50);
    wait_ctr(300);
    commit();
    run = 1'b0;
    q_done.delete();
    q_done.push_back('{cyc + 1, 32'd1});
    commit_edge = cyc + 1;
    tick(1);
    check_eq("stop_ctr", 32'(ctr), 32'd0);
    check_eq("stop_cmp_ch5", 32'(ch_compare[5*CTR_W +: CTR_W]), 32'd100);
    tick(20);
    check_eq("stop_ctr_hold", 32'(ctr), 32'd0);
    run = 1'b1;
    wait_ctr(100);

    // reset while pending discards the commit and clears the banks
    wr(3'd6, 11'd7, 11'd600);
    wait_ctr(650);
    commit();
    wait_ctr(700);
    rst = 1'b1;
    #1;
    check_eq("arst_ctr", 32'(ctr), 32'd0);
    check_eq("arst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("arst_compare", 32'(|ch_compare), 32'd0);
    check_eq("arst_done", 32'(commit_done), 32'd0);
    tick(2);
    rst = 1'b0;
    wait_ctr(PMAX);
    wait_ctr(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
